pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised fetch-stage program counter. It replaces the single-mode PC register with a next-PC selector for sequential, branch, JALR and trap redirects. It also provides stall support, deferral of a redirect that arrives during a stall, misaligned-target detection, and a registered IF/ID copy of the fetch PC. It sits between control/execute (redirect sources) and instruction memory (fetch address) / decode (PC of the fetched instruction).

Parameters:
ADDR_WIDTH, 32, width of all PC/address/immediate datapaths
RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap redirect or misaligned target
INSTR_BYTES, 4, sequential increment; also sets the alignment requirement (must be a power of 2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hold PC and IF/ID outputs this cycle
redirect  input  1  redirect request valid this cycle
redirect_type  input  2  0=branch (base_pc+imm), 1=jalr ((rs1_val+imm) with bit0 cleared), 2=trap (TRAP_VECTOR), 3=reserved (treated as trap)
base_pc  input  ADDR_WIDTH  PC of the redirecting instruction
imm  input  ADDR_WIDTH  sign-extended immediate
rs1_val  input  ADDR_WIDTH  register operand for jalr
pc  output  ADDR_WIDTH  current fetch address
pc_plus  output  ADDR_WIDTH  pc + INSTR_BYTES (combinational)
pc_d  output  ADDR_WIDTH  IF/ID registered PC of fetched instruction
pc_plus_d  output  ADDR_WIDTH  IF/ID registered pc_plus
valid_d  output  1  IF/ID slot holds a valid instruction
misaligned  output  1  one-cycle pulse: a redirect target was misaligned and was replaced by TRAP_VECTOR
pending  output  1  a deferred redirect is held (state HOLD)

Behaviour:
- Reset (rst=1 on a rising edge, overrides every other input):
  - pc=RESET_VECTOR; pc_d=0; pc_plus_d=0; valid_d=0; misaligned=0; pending=0; state=RUN; pending target register=0.
- Arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent (all-ones + 4 -> 3 with INSTR_BYTES=4).
- Target computation (combinational):
  - branch = base_pc+imm.
  - jalr = (rs1_val+imm) & ~1.
  - trap/reserved = TRAP_VECTOR.
  - Target is misaligned if target mod INSTR_BYTES != 0 (trap vector is never checked). A misaligned target is replaced by TRAP_VECTOR and misaligned pulses high the next cycle.
- State RUN, stall=0:
  - redirect=1: pc<=target; valid_d<=0 (flush); pc_d/pc_plus_d unchanged.
  - redirect=0: pc<=pc_plus; pc_d<=pc; pc_plus_d<=pc_plus; valid_d<=1.
- State RUN, stall=1:
  - pc, pc_d, pc_plus_d, valid_d hold.
  - redirect=1: latch the (alignment-corrected) target into the pending register, go to HOLD, pending<=1. misaligned still pulses on capture.
- State HOLD, stall=1:
  - Outputs hold.
  - A new redirect overwrites the pending target (newest wins).
- State HOLD, stall=0:
  - redirect=1: the live target wins over the pending one.
  - redirect=0: pc<=pending target.
  - In both cases: valid_d<=0, state<=RUN, pending<=0.
- Latency: redirect visible on pc one cycle after the accepting edge; no bubble beyond the single flushed IF/ID slot.
- Reset asserted while in HOLD discards the pending target.

Decomposition:
- Shared package pc_pkg holds:
  - enum redirect_type_t (BR, JALR, TRAP, RSVD).
  - enum pc_state_t (RUN, HOLD).
  - Default-vector localparams.
- One natural sub-module: pc_target_calc, combinational target mux plus alignment check, reused by a future branch predictor.

Test Plan:
- Reset release, 3 free cycles -> pc 0x0,0x4,0x8,0xC; valid_d 0 then 1; pc_d lags pc by one cycle.
- At pc=0x8, branch with base_pc=0x4, imm=0x20 -> pc=0x24 next cycle, valid_d=0 for one cycle, then sequential from 0x28.
- jalr with rs1_val=0x101, imm=0x2 -> target 0x102, misaligned; pc=0x100 (TRAP_VECTOR), misaligned=1 for exactly one cycle.
- stall=1 for 3 cycles with branch target 0x40 in cycle 1 and jalr target 0x80 in cycle 2 -> pending=1, pc held; on stall release pc=0x80, valid_d=0, pending=0.
- Pending redirect held, then rst=1 -> pc=RESET_VECTOR, pending=0, no later jump to the stale target.
- pc=0xFFFF_FFFC sequential -> pc wraps to 0x0000_0000, no flag raised.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared types and default vectors for the fetch-stage program counter.
package pc_pkg;

  typedef enum logic [1:0] {
    BR   = 2'd0,
    JALR = 2'd1,
    TRAP = 2'd2,
    RSVD = 2'd3
  } redirect_type_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          DEFAULT_INSTR_BYTES  = 4;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target mux with alignment check; a misaligned target is replaced by the trap vector.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = ADDR_WIDTH'(DEFAULT_TRAP_VECTOR),
  parameter int                    INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
  input  logic [1:0]            redirect_type,
  input  logic [ADDR_WIDTH-1:0] base_pc,
  input  logic [ADDR_WIDTH-1:0] imm,
  input  logic [ADDR_WIDTH-1:0] rs1_val,
  output logic [ADDR_WIDTH-1:0] target,
  output logic                  misaligned
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LSB_CLEAR  = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  logic [ADDR_WIDTH-1:0] jalr_sum;
  logic [ADDR_WIDTH-1:0] raw_target;
  logic                  check_align;

  assign jalr_sum = rs1_val + imm;

  always_comb begin
    raw_target  = TRAP_VECTOR;
    check_align = 1'b0;
    case (redirect_type)
      BR: begin
        raw_target  = base_pc + imm;
        check_align = 1'b1;
      end
      JALR: begin
        raw_target  = jalr_sum & LSB_CLEAR;
        check_align = 1'b1;
      end
      default: begin
        // Trap and reserved both go to the trap vector, which is trusted to be aligned.
        raw_target  = TRAP_VECTOR;
        check_align = 1'b0;
      end
    endcase
  end

  assign misaligned = check_align && ((raw_target & ALIGN_MASK) != '0);
  assign target     = misaligned ? TRAP_VECTOR : raw_target;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC with redirect selection, stall-time redirect deferral and an IF/ID PC register.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'(DEFAULT_TRAP_VECTOR),
  parameter int                    INSTR_BYTES  = DEFAULT_INSTR_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [1:0]            redirect_type,
  input  logic [ADDR_WIDTH-1:0] base_pc,
  input  logic [ADDR_WIDTH-1:0] imm,
  input  logic [ADDR_WIDTH-1:0] rs1_val,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus,
  output logic [ADDR_WIDTH-1:0] pc_d,
  output logic [ADDR_WIDTH-1:0] pc_plus_d,
  output logic                  valid_d,
  output logic                  misaligned,
  output logic                  pending
);

  pc_state_t             state_reg;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ADDR_WIDTH-1:0] pc_d_reg;
  logic [ADDR_WIDTH-1:0] pc_plus_d_reg;
  logic [ADDR_WIDTH-1:0] pending_target_reg;
  logic                  valid_d_reg;
  logic                  misaligned_reg;
  logic                  pending_reg;

  logic [ADDR_WIDTH-1:0] pc_plus_w;
  logic [ADDR_WIDTH-1:0] target;
  logic                  target_misaligned;

  pc_target_calc #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .TRAP_VECTOR (TRAP_VECTOR),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_target_calc (
    .redirect_type (redirect_type),
    .base_pc       (base_pc),
    .imm           (imm),
    .rs1_val       (rs1_val),
    .target        (target),
    .misaligned    (target_misaligned)
  );

  assign pc_plus_w = pc_reg + ADDR_WIDTH'(INSTR_BYTES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= RUN;
      pc_reg             <= RESET_VECTOR;
      pc_d_reg           <= '0;
      pc_plus_d_reg      <= '0;
      pending_target_reg <= '0;
      valid_d_reg        <= 1'b0;
      misaligned_reg     <= 1'b0;
      pending_reg        <= 1'b0;
    end else begin
      // Pulse whenever a redirect is sampled, whether it is taken now or deferred.
      misaligned_reg <= redirect && target_misaligned;
      case (state_reg)
        RUN: begin
          if (!stall) begin
            if (redirect) begin
              pc_reg      <= target;
              valid_d_reg <= 1'b0;
            end else begin
              pc_reg        <= pc_plus_w;
              pc_d_reg      <= pc_reg;
              pc_plus_d_reg <= pc_plus_w;
              valid_d_reg   <= 1'b1;
            end
          end else if (redirect) begin
            pending_target_reg <= target;
            state_reg          <= HOLD;
            pending_reg        <= 1'b1;
          end
        end
        HOLD: begin
          if (stall) begin
            if (redirect) begin
              pending_target_reg <= target;
            end
          end else begin
            // A live redirect is younger than the deferred one, so it takes priority.
            pc_reg      <= redirect ? target : pending_target_reg;
            valid_d_reg <= 1'b0;
            state_reg   <= RUN;
            pending_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= RUN;
          pending_reg <= 1'b0;
        end
      endcase
    end
  end

  assign pc         = pc_reg;
  assign pc_plus    = pc_plus_w;
  assign pc_d       = pc_d_reg;
  assign pc_plus_d  = pc_plus_d_reg;
  assign valid_d    = valid_d_reg;
  assign misaligned = misaligned_reg;
  assign pending    = pending_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expected post-edge state is queued on drive and checked after the edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [1:0]  redirect_type;
  logic [31:0] base_pc;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic [31:0] pc_d;
  logic [31:0] pc_plus_d;
  logic        valid_d;
  logic        misaligned;
  logic        pending;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] pc_plus_d;
    logic        valid_d;
    logic        misaligned;
    logic        pending;
  } exp_t;

  exp_t exp_q[$];

  pc_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_type (redirect_type),
    .base_pc       (base_pc),
    .imm           (imm),
    .rs1_val       (rs1_val),
    .pc            (pc),
    .pc_plus       (pc_plus),
    .pc_d          (pc_d),
    .pc_plus_d     (pc_plus_d),
    .valid_d       (valid_d),
    .misaligned    (misaligned),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  task automatic check_out();
    exp_t        e;
    logic [31:0] e_plus;
    tests++;
    assert (exp_q.size() > 0) else begin
      fails++;
      $error("FAIL scoreboard_empty observed=%0d expected=>0", exp_q.size());
    end
    if (exp_q.size() > 0) begin
      e      = exp_q.pop_front();
      e_plus = e.pc + 32'd4;
      tests++;
      assert (pc === e.pc) else begin
        fails++;
        $error("FAIL %s.pc observed=%h expected=%h", e.tag, pc, e.pc);
      end
      tests++;
      assert (pc_plus === e_plus) else begin
        fails++;
        $error("FAIL %s.pc_plus observed=%h expected=%h", e.tag, pc_plus, e_plus);
      end
      tests++;
      assert (pc_d === e.pc_d) else begin
        fails++;
        $error("FAIL %s.pc_d observed=%h expected=%h", e.tag, pc_d, e.pc_d);
      end
      tests++;
      assert (pc_plus_d === e.pc_plus_d) else begin
        fails++;
        $error("FAIL %s.pc_plus_d observed=%h expected=%h", e.tag, pc_plus_d, e.pc_plus_d);
      end
      tests++;
      assert (valid_d === e.valid_d) else begin
        fails++;
        $error("FAIL %s.valid_d observed=%b expected=%b", e.tag, valid_d, e.valid_d);
      end
      tests++;
      assert (misaligned === e.misaligned) else begin
        fails++;
        $error("FAIL %s.misaligned observed=%b expected=%b", e.tag, misaligned, e.misaligned);
      end
      tests++;
      assert (pending === e.pending) else begin
        fails++;
        $error("FAIL %s.pending observed=%b expected=%b", e.tag, pending, e.pending);
      end
      $display("[TB] %-12s pc=%h pc_d=%h pc_plus_d=%h valid_d=%b mis=%b pend=%b",
               e.tag, pc, pc_d, pc_plus_d, valid_d, misaligned, pending);
    end
  endtask

  // Drive one cycle of inputs, queue the state expected after the next rising edge, then check it.
  task automatic step(input string tag, input logic r, input logic s, input logic rd,
                      input logic [1:0] ty, input logic [31:0] b, input logic [31:0] i,
                      input logic [31:0] r1, input logic [31:0] e_pc, input logic [31:0] e_pd,
                      input logic [31:0] e_ppd, input logic e_v, input logic e_m, input logic e_p);
    exp_t e;
    rst           = r;
    stall         = s;
    redirect      = rd;
    redirect_type = ty;
    base_pc       = b;
    imm           = i;
    rs1_val       = r1;
    e.tag        = tag;
    e.pc         = e_pc;
    e.pc_d       = e_pd;
    e.pc_plus_d  = e_ppd;
    e.valid_d    = e_v;
    e.misaligned = e_m;
    e.pending    = e_p;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_type = 2'd0;
    base_pc = '0; imm = '0; rs1_val = '0;

    //   tag            rst st rd ty   base          imm           rs1        | pc            pc_d          pc_plus_d   v  m  p
    step("reset",       1, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h0,        32'h0,        32'h0,      0, 0, 0);
    step("seq1",        0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h4,        32'h0,        32'h4,      1, 0, 0);
    step("seq2",        0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h8,        32'h4,        32'h8,      1, 0, 0);
    step("branch",      0, 0, 1, 2'd0, 32'h4,        32'h20,       32'h0,       32'h24,       32'h4,        32'h8,      0, 0, 0);
    step("after_br",    0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h28,       32'h24,       32'h28,     1, 0, 0);
    step("after_br2",   0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h2C,       32'h28,       32'h2C,     1, 0, 0);
    step("jalr_mis",    0, 0, 1, 2'd1, 32'h0,        32'h2,        32'h101,     32'h100,      32'h28,       32'h2C,     0, 1, 0);
    step("after_mis",   0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h104,      32'h100,      32'h104,    1, 0, 0);
    step("jalr_ok",     0, 0, 1, 2'd1, 32'h0,        32'h3,        32'h201,     32'h204,      32'h100,      32'h104,    0, 0, 0);
    step("after_jalr",  0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h208,      32'h204,      32'h208,    1, 0, 0);
    step("stall_br",    0, 1, 1, 2'd0, 32'h30,       32'h10,       32'h0,       32'h208,      32'h204,      32'h208,    1, 0, 1);
    step("stall_jalr",  0, 1, 1, 2'd1, 32'h0,        32'h1,        32'h7F,      32'h208,      32'h204,      32'h208,    1, 0, 1);
    step("stall_idle",  0, 1, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h208,      32'h204,      32'h208,    1, 0, 1);
    step("release",     0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h80,       32'h204,      32'h208,    0, 0, 0);
    step("after_rel",   0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h84,       32'h80,       32'h84,     1, 0, 0);
    step("hold_br",     0, 1, 1, 2'd0, 32'h0,        32'h300,      32'h0,       32'h84,       32'h80,       32'h84,     1, 0, 1);
    step("live_trap",   0, 0, 1, 2'd2, 32'h0,        32'h0,        32'h0,       32'h100,      32'h80,       32'h84,     0, 0, 0);
    step("after_trap",  0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h104,      32'h100,      32'h104,    1, 0, 0);
    step("neg_imm",     0, 0, 1, 2'd0, 32'h100,      32'hFFFF_FFF8, 32'h0,      32'hF8,       32'h100,      32'h104,    0, 0, 0);
    step("rsvd",        0, 0, 1, 2'd3, 32'h0,        32'h2,        32'h3,       32'h100,      32'h100,      32'h104,    0, 0, 0);
    step("stall_mis",   0, 1, 1, 2'd0, 32'h0,        32'h2,        32'h0,       32'h100,      32'h100,      32'h104,    0, 1, 1);
    step("stall_idle2", 0, 1, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h100,      32'h100,      32'h104,    0, 0, 1);
    step("rst_hold",    1, 1, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h0,        32'h0,        32'h0,      0, 0, 0);
    step("post_rst",    0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h4,        32'h0,        32'h4,      1, 0, 0);
    step("post_rst2",   0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h8,        32'h4,        32'h8,      1, 0, 0);
    step("to_top",      0, 0, 1, 2'd0, 32'hFFFF_FFF0, 32'hC,       32'h0,       32'hFFFF_FFFC, 32'h4,       32'h8,      0, 0, 0);
    step("wrap",        0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h0,        32'hFFFF_FFFC, 32'h0,     1, 0, 0);
    step("wrap2",       0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0,       32'h4,        32'h0,        32'h4,      1, 0, 0);

    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
